// File: rtl/gs_div_ctrl.sv
// ---------------------------------------------------------------------------
// gs_div_ctrl
//
// Purpose:
//   Sequencer for a two-stage Goldschmidt division datapath. The datapath has
//   two stages: the K generator / operand select stage, and the CSAM multiply
//   plus RNE round stage.
//   On an accepted start it latches the dividend, the divisor and the initial
//   reciprocal approximation. It then alternates D and N phases for ITERS
//   iterations, feeding the previous products back in as the new operands.
//   After a two-cycle drain it captures the rounded quotient and raises a
//   one-cycle done pulse. The block does no arithmetic itself: the datapath
//   forms K = 2 - D*K from the fed-back product.
//
// Parameters:
//   ITERS          number of Goldschmidt iterations (1..7)
//   WIDTH          operand/result width, must match the datapath
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_start        request, sampled only while o_busy = 0
//   i_n_in         dividend, latched on an accepted start
//   i_d_in         divisor, latched on an accepted start
//   i_ia_in        initial reciprocal approximation, latched on an accepted start
//   o_busy         high while a division is in flight
//   o_done         one-cycle pulse, o_q valid from this cycle
//   o_q            quotient, held until the next capture
//   o_dp_k_select  datapath kSelect  (0 = IA, 1 = 2 - previous result)
//   o_dp_nd_select datapath ndSelect (0 = D and K loads, 1 = N and K holds)
//   o_dp_n/o_dp_d  datapath N / D operands
//   o_dp_ia        datapath IA operand (the latched approximation)
//   i_dp_result    datapath result (2-cycle latency)
//   o_dz           divide-by-zero flag (only with GS_DIVZERO_EN)
//
// Build option:
//   GS_DIVZERO_EN  when defined, a start with i_d_in = 0 completes at once.
//                  It returns q = all ones and raises o_dz.
// ---------------------------------------------------------------------------
module gs_div_ctrl #(
  parameter int ITERS = 3,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n_in,
  input  logic [WIDTH-1:0] i_d_in,
  input  logic [WIDTH-1:0] i_ia_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_q,
  output logic             o_dp_k_select,
  output logic             o_dp_nd_select,
  output logic [WIDTH-1:0] o_dp_n,
  output logic [WIDTH-1:0] o_dp_d,
  output logic [WIDTH-1:0] o_dp_ia,
  input  logic [WIDTH-1:0] i_dp_result
`ifdef GS_DIVZERO_EN
  ,
  output logic             o_dz
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] LAST_I = 3'(ITERS - 1);

  state_t           r_state, w_state_next;
  logic             r_phase, w_phase_next;   // 0 = D phase, 1 = N phase
  logic [2:0]       r_i, w_i_next;           // iteration counter
  logic             r_drain, w_drain_next;   // drain cycle counter
  logic [WIDTH-1:0] r_n, w_n_next;
  logic [WIDTH-1:0] r_d, w_d_next;
  logic [WIDTH-1:0] r_ia, w_ia_next;
  logic [WIDTH-1:0] r_q, w_q_next;
  logic             r_done, w_done_next;
`ifdef GS_DIVZERO_EN
  logic             r_dz, w_dz_next;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
      r_i     <= 3'd0;
      r_drain <= 1'b0;
      r_n     <= '0;
      r_d     <= '0;
      r_ia    <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
`ifdef GS_DIVZERO_EN
      r_dz    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_i     <= w_i_next;
      r_drain <= w_drain_next;
      r_n     <= w_n_next;
      r_d     <= w_d_next;
      r_ia    <= w_ia_next;
      r_q     <= w_q_next;
      r_done  <= w_done_next;
`ifdef GS_DIVZERO_EN
      r_dz    <= w_dz_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_phase_next   = r_phase;
    w_i_next       = r_i;
    w_drain_next   = r_drain;
    w_n_next       = r_n;
    w_d_next       = r_d;
    w_ia_next      = r_ia;
    w_q_next       = r_q;
    w_done_next    = 1'b0;
`ifdef GS_DIVZERO_EN
    w_dz_next      = r_dz;
`endif
    // Idle/drain default: K register holds, operands show the latched values.
    o_dp_nd_select = 1'b1;
    o_dp_k_select  = 1'b0;
    o_dp_n         = r_n;
    o_dp_d         = r_d;
    o_dp_ia        = r_ia;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_n_next     = i_n_in;
          w_d_next     = i_d_in;
          w_ia_next    = i_ia_in;
          w_i_next     = 3'd0;
          w_phase_next = 1'b0;
          w_drain_next = 1'b0;
`ifdef GS_DIVZERO_EN
          w_dz_next    = 1'b0;
          if (i_d_in == '0) begin
            // Zero divisor: finish immediately without touching the datapath.
            w_dz_next   = 1'b1;
            w_q_next    = '1;
            w_done_next = 1'b1;
          end else begin
            w_state_next = S_ITER;
          end
`else
          w_state_next = S_ITER;
`endif
        end
      end

      S_ITER: begin
        if (!r_phase) begin
          // D phase: K loads, either from IA (first pass) or from 2 - D*K.
          o_dp_nd_select = 1'b0;
          o_dp_k_select  = (r_i != 3'd0);
          // Bypass: the previous iteration's D*K arrives on dp_result just now.
          if (r_i != 3'd0) begin
            o_dp_d = i_dp_result;
          end
          w_phase_next = 1'b1;
        end else begin
          // N phase: K holds; the previous iteration's N*K is on dp_result.
          if (r_i != 3'd0) begin
            o_dp_n = i_dp_result;
          end
          w_phase_next = 1'b0;
          w_i_next     = r_i + 3'd1;
          if (r_i == LAST_I) begin
            w_state_next = S_DRAIN;
            w_drain_next = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        // The last N*K leaves the two-stage datapath on the second cycle.
        w_drain_next = 1'b1;
        if (r_drain) begin
          w_q_next     = i_dp_result;
          w_done_next  = 1'b1;
          w_drain_next = 1'b0;
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_q    = r_q;
`ifdef GS_DIVZERO_EN
  assign o_dz   = r_dz;
`endif

endmodule

// File: tb/tb_gs_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gs_div_ctrl
//
// Purpose:
//   Self-checking bench for gs_div_ctrl. A cycle-level model of the two-stage
//   Goldschmidt datapath is attached to the dp_* ports. This model is fixed
//   point with 14 fraction bits, round to nearest, and 2-cycle latency.
//   Expected quotients come from a separate algorithmic model. They are
//   pushed to a queue at each start and popped when done pulses.
//   Define GS_DIVZERO_EN to also exercise the divide-by-zero path.
// ---------------------------------------------------------------------------
module tb_gs_div_ctrl;
  localparam int ITERS = 3;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] n_in = '0;
  logic [WIDTH-1:0] d_in = '0;
  logic [WIDTH-1:0] ia_in = '0;
  logic             busy, done;
  logic [WIDTH-1:0] q;
  logic             dp_k_sel, dp_nd_sel;
  logic [WIDTH-1:0] dp_n, dp_d, dp_ia, dp_result;
`ifdef GS_DIVZERO_EN
  logic             dz;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  gs_div_ctrl #(.ITERS(ITERS), .WIDTH(WIDTH)) dut (
    .i_clk          (clk),
    .i_reset        (reset_n),
    .i_start        (start),
    .i_n_in         (n_in),
    .i_d_in         (d_in),
    .i_ia_in        (ia_in),
    .o_busy         (busy),
    .o_done         (done),
    .o_q            (q),
    .o_dp_k_select  (dp_k_sel),
    .o_dp_nd_select (dp_nd_sel),
    .o_dp_n         (dp_n),
    .o_dp_d         (dp_d),
    .o_dp_ia        (dp_ia),
    .i_dp_result    (dp_result)
`ifdef GS_DIVZERO_EN
    ,
    .o_dz           (dz)
`endif
  );

  // Fixed-point multiply with 14 fraction bits, round half up.
  function automatic logic [15:0] mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'b0, a} * {16'b0, b};
    p = p + 32'h0000_2000;
    return p[29:14];
  endfunction

  // Algorithmic Goldschmidt reference.
  function automatic logic [15:0] gs_expect(input logic [15:0] n, input logic [15:0] d,
                                            input logic [15:0] ia);
    logic [15:0] nn, dd, k, t;
    nn = n;
    dd = d;
    k  = ia;
    for (int it = 0; it < ITERS; it++) begin
      if (it != 0) k = 16'h8000 - dd;
      t  = mul(dd, k);
      nn = mul(nn, k);
      dd = t;
    end
    return nn;
  endfunction

  // Datapath model: K register, multiply stage, round stage.
  logic [15:0] m_k_reg = '0;
  logic [15:0] m_s1 = '0;
  logic [15:0] m_s2 = '0;
  logic [15:0] m_kcur, m_op;
  always_comb begin
    m_kcur = dp_nd_sel ? m_k_reg : (dp_k_sel ? (16'h8000 - dp_result) : dp_ia);
    m_op   = dp_nd_sel ? dp_n : dp_d;
  end
  always @(posedge clk) begin
    if (!dp_nd_sel) m_k_reg <= m_kcur;
    m_s1 <= mul(m_op, m_kcur);
    m_s2 <= m_s1;
  end
  assign dp_result = m_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present a start request with operands and record the expected quotient.
  task automatic drive(input logic [15:0] n, input logic [15:0] d, input logic [15:0] ia);
    start = 1'b1;
    n_in  = n;
    d_in  = d;
    ia_in = ia;
    exp_q.push_back(gs_expect(n, d, ia));
  endtask

  // Step negedges until done (bounded), then score the quotient.
  task automatic wait_done(input string tag, input int limit, input bit hold, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
    end while (!done && cyc < limit);
    chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    if (done) begin
      chk({tag, "_sb_nonempty"}, {31'b0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk({tag, "_q"}, {16'b0, q}, {16'b0, e});
        $display("txn %s: q=%h expected=%h after %0d cycles", tag, q, e, cyc);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    logic [7:0]  nd_pat;
    logic [7:0]  k_pat;
    logic [15:0] res7, qsave;

    // ---- reset state ----
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'b0, busy},      32'd0);
    chk("rst_done",   {31'b0, done},      32'd0);
    chk("rst_q",      {16'b0, q},         32'd0);
    chk("rst_nd",     {31'b0, dp_nd_sel}, 32'd1);
    chk("rst_k",      {31'b0, dp_k_sel},  32'd0);
    chk("rst_dp_n",   {16'b0, dp_n},      32'd0);
    chk("rst_dp_d",   {16'b0, dp_d},      32'd0);
    chk("rst_dp_ia",  {16'b0, dp_ia},     32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- sequence check ----
    nd_pat = 8'b1110_1010;
    k_pat  = 8'b0001_0100;
    drive(16'h4000, 16'h6000, 16'h5555);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      chk($sformatf("seq_nd_c%0d", c),   {31'b0, dp_nd_sel}, {31'b0, nd_pat[c]});
      chk($sformatf("seq_k_c%0d", c),    {31'b0, dp_k_sel},  {31'b0, k_pat[c]});
      chk($sformatf("seq_busy_c%0d", c), {31'b0, busy},      32'd1);
      chk($sformatf("seq_done_c%0d", c), {31'b0, done},      32'd0);
      if (c == 0) begin
        chk("seq_dp_d_c0",  {16'b0, dp_d},  32'h6000);
        chk("seq_dp_ia_c0", {16'b0, dp_ia}, 32'h5555);
      end
      if (c == 1) chk("seq_dp_n_c1", {16'b0, dp_n}, 32'h4000);
      if (c == 7) res7 = dp_result;
    end
    wait_done("seq", 1, 1'b0, cyc);
    chk("seq_q_eq_res_c7", {16'b0, q}, {16'b0, res7});
    chk("seq_busy_c8",     {31'b0, busy}, 32'd0);

    // ---- q holds through idle ----
    qsave = q;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_q_stable", {16'b0, q},    {16'b0, qsave});
      chk("idle_no_done",  {31'b0, done}, 32'd0);
    end

    // ---- busy collision ----
    drive(16'h3000, 16'h5000, 16'h6666);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
    end
    start = 1'b1;              // start high during c3 with other operands
    n_in  = 16'h1234;
    d_in  = 16'h7000;
    ia_in = 16'h4924;
    wait_done("collide", 10, 1'b0, cyc);
    chk("collide_latency", cyc, 32'd5);
    @(negedge clk);
    chk("collide_no_extra_done", {31'b0, done}, 32'd0);

    // ---- back-to-back with start held high ----
    drive(16'h2000, 16'h4800, 16'h7000);
    wait_done("b2b1", 20, 1'b1, cyc);
    chk("b2b1_period", cyc, 32'd9);
    drive(16'h3800, 16'h6800, 16'h4e00);
    wait_done("b2b2", 20, 1'b1, cyc);
    chk("b2b2_period", cyc, 32'd9);
    drive(16'h1000, 16'h5800, 16'h5c00);
    wait_done("b2b3", 20, 1'b1, cyc);
    chk("b2b3_period", cyc, 32'd9);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_stop_busy", {31'b0, busy}, 32'd0);

    // ---- reset mid-ITER ----
    drive(16'h4000, 16'h6000, 16'h5555);
    void'(exp_q.pop_back());   // this run is aborted
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk("arst_busy_now", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("arst_busy", {31'b0, busy},      32'd0);
    chk("arst_done", {31'b0, done},      32'd0);
    chk("arst_q",    {16'b0, q},         32'd0);
    chk("arst_nd",   {31'b0, dp_nd_sel}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    drive(16'h2c00, 16'h7400, 16'h4600);
    wait_done("post_rst", 20, 1'b0, cyc);
    chk("post_rst_latency", cyc, 32'd9);

`ifdef GS_DIVZERO_EN
    // ---- divide by zero ----
    @(negedge clk);
    start = 1'b1;
    n_in  = 16'h4000;
    d_in  = 16'h0000;
    ia_in = 16'h5555;
    exp_q.push_back(16'hFFFF);
    wait_done("dz", 1, 1'b0, cyc);
    chk("dz_flag", {31'b0, dz},   32'd1);
    chk("dz_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    drive(16'h4000, 16'h6000, 16'h5555);
    @(negedge clk);
    start = 1'b0;
    chk("dz_clear", {31'b0, dz}, 32'd0);
    wait_done("dz_next", 20, 1'b0, cyc);
    chk("dz_next_latency", cyc, 32'd8);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
